// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
// Holds the arbiter state encoding and default latency/width values.
package mem_port_arbiter_pkg;

  localparam int DEF_LATENCY    = 2;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals of the arbiter.
// master: arbiter view (drives ready/rdata/mem*/stall); slave: pipeline+memory view.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic                  ifReq;
  logic [ADDR_WIDTH-1:0] ifAddr;
  logic                  ifReady;
  logic [DATA_WIDTH-1:0] ifRdata;

  logic                  dmReq;
  logic                  dmWrite;
  logic [ADDR_WIDTH-1:0] dmAddr;
  logic [DATA_WIDTH-1:0] dmWdata;
  logic                  dmReady;
  logic [DATA_WIDTH-1:0] dmRdata;

  logic                  memEn;
  logic                  memWe;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic [DATA_WIDTH-1:0] memWdata;
  logic [DATA_WIDTH-1:0] memRdata;

  logic                  stall;

  modport master (
    input  ifReq, ifAddr,
    output ifReady, ifRdata,
    input  dmReq, dmWrite, dmAddr, dmWdata,
    output dmReady, dmRdata,
    output memEn, memWe, memAddr, memWdata,
    input  memRdata,
    output stall
  );

  modport slave (
    output ifReq, ifAddr,
    input  ifReady, ifRdata,
    output dmReq, dmWrite, dmAddr, dmWdata,
    input  dmReady, dmRdata,
    input  memEn, memWe, memAddr, memWdata,
    output memRdata,
    input  stall
  );

endinterface

// File: rtl/mem_port_arbiter_latency_counter.sv
// Down-counter timing one fixed-latency memory access.
// Ports: clock, reset, load (preset to LATENCY-1), dec, zero flag.
module mem_port_arbiter_latency_counter #(
  parameter int LATENCY = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int CW = $clog2(LATENCY) + 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(LATENCY - 1);
    end else if (dec && cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported fixed-latency memory between IF and MEM stage.
// Ports: clock, reset, bus (fetch/data requests, memory side, pipeline stall).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int LATENCY    = DEF_LATENCY,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input logic                clock,
  input logic                reset,
  mem_port_arbiter_if.master bus
);

  state_t state, state_nx;

  logic                  if_pend, dm_pend, stall;
  logic                  grant_i, grant_d, done, cnt_zero;
  logic                  if_ready_q, dm_ready_q, we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, if_rdata_q, dm_rdata_q;

  assign if_pend = bus.ifReq & ~if_ready_q;
  assign dm_pend = bus.dmReq & ~dm_ready_q;
  assign stall   = if_pend | dm_pend;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Data beats fetch: the MEM-stage op belongs to the older instruction.
  always_comb begin
    state_nx = state;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (dm_pend) begin
          grant_d  = 1'b1;
          state_nx = BUSY_D;
        end else if (if_pend) begin
          grant_i  = 1'b1;
          state_nx = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (cnt_zero) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  mem_port_arbiter_latency_counter #(
    .LATENCY(LATENCY)
  ) u_cnt (
    .clock(clock),
    .reset(reset),
    .load (grant_i | grant_d),
    .dec  (state != IDLE),
    .zero (cnt_zero)
  );

  // Ready flags hold until the pipeline advances (stall low),
  // and are only set if the requester has not been flushed.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
    end else begin
      if (grant_d) begin
        addr_q  <= bus.dmAddr;
        wdata_q <= bus.dmWdata;
        we_q    <= bus.dmWrite;
      end else if (grant_i) begin
        addr_q  <= bus.ifAddr;
      end
      if (done && state == BUSY_I) if_rdata_q <= bus.memRdata;
      if (done && state == BUSY_D) dm_rdata_q <= bus.memRdata;
      if (!stall) begin
        if_ready_q <= 1'b0;
        dm_ready_q <= 1'b0;
      end else begin
        if (done && state == BUSY_I && bus.ifReq) if_ready_q <= 1'b1;
        if (done && state == BUSY_D && bus.dmReq) dm_ready_q <= 1'b1;
      end
    end
  end

  assign bus.memEn    = (state != IDLE);
  assign bus.memWe    = (state == BUSY_D) & we_q;
  assign bus.memAddr  = addr_q;
  assign bus.memWdata = wdata_q;
  assign bus.ifReady  = if_ready_q;
  assign bus.ifRdata  = if_rdata_q;
  assign bus.dmReady  = dm_ready_q;
  assign bus.dmRdata  = dm_rdata_q;
  assign bus.stall    = stall;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (LATENCY=2 and LATENCY=1).
// Directed spec scenarios, then randomized traffic against a timestamp model.
module tb_mem_port_arbiter;

  logic clock;
  logic reset;

  int n_assert = 0;
  int n_fail   = 0;

  mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus2 ();
  mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();

  mem_port_arbiter #(.LATENCY(2)) dut2 (
    .clock(clock), .reset(reset), .bus(bus2)
  );
  mem_port_arbiter #(.LATENCY(1)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'h2048_0005;
  endfunction

  // Memory returns valid data only in the last cycle of an access.
  int mcnt2 = 0;
  int mcnt1 = 0;
  always @(posedge clock) begin
    mcnt2 <= (bus2.memEn === 1'b1) ? mcnt2 + 1 : 0;
    mcnt1 <= (bus1.memEn === 1'b1) ? mcnt1 + 1 : 0;
  end
  assign bus2.memRdata = (bus2.memEn === 1'b1 && mcnt2 == 1) ?
                         mem_f(bus2.memAddr) : 32'hBAD0_BAD0;
  assign bus1.memRdata = (bus1.memEn === 1'b1 && mcnt1 == 0) ?
                         mem_f(bus1.memAddr) : 32'hBAD0_BAD0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Reference model state (timestamp based)
  localparam int L = 2;
  int          g;
  bit          act, kd, m_we, r_if, r_dm, adv, done, p_i, p_d, es;
  logic [31:0] m_addr, m_wdata, rd_if, rd_dm;

  initial begin
    clock = 0;
    reset = 1;
    {bus2.ifReq, bus2.dmReq, bus2.dmWrite} = '0;
    {bus1.ifReq, bus1.dmReq, bus1.dmWrite} = '0;
    bus2.ifAddr = '0; bus2.dmAddr = '0; bus2.dmWdata = '0;
    bus1.ifAddr = '0; bus1.dmAddr = '0; bus1.dmWdata = '0;
    tick();
    tick();
    chk("rst_memEn", bus2.memEn, 0);
    chk("rst_memWe", bus2.memWe, 0);
    chk("rst_memAddr", bus2.memAddr, 0);
    chk("rst_memWdata", bus2.memWdata, 0);
    chk("rst_ifReady", bus2.ifReady, 0);
    chk("rst_dmReady", bus2.dmReady, 0);
    chk("rst_ifRdata", bus2.ifRdata, 0);
    chk("rst_dmRdata", bus2.dmRdata, 0);
    chk("rst_stall", bus2.stall, 0);
    reset = 0;

    // 1: single fetch, LATENCY=2
    bus2.ifReq = 1; bus2.ifAddr = 32'h0040_0000;
    #1 chk("t1_c0_stall", bus2.stall, 1);
    chk("t1_c0_memEn", bus2.memEn, 0);
    tick();
    chk("t1_c1_memEn", bus2.memEn, 1);
    chk("t1_c1_memAddr", bus2.memAddr, 32'h0040_0000);
    chk("t1_c1_stall", bus2.stall, 1);
    tick();
    chk("t1_c2_memEn", bus2.memEn, 1);
    chk("t1_c2_stall", bus2.stall, 1);
    tick();
    chk("t1_c3_ifReady", bus2.ifReady, 1);
    chk("t1_c3_ifRdata", bus2.ifRdata, 32'h2008_0005);
    chk("t1_c3_memEn", bus2.memEn, 0);
    chk("t1_c3_stall", bus2.stall, 0);
    bus2.ifReq = 0;
    tick();
    chk("t1_c4_ifReady", bus2.ifReady, 0);

    // 2: fetch and load together -> data first
    bus2.ifReq = 1; bus2.ifAddr = 32'h0040_0004;
    bus2.dmReq = 1; bus2.dmWrite = 0; bus2.dmAddr = 32'h1001_0000;
    tick();
    chk("t2_c1_memAddr", bus2.memAddr, 32'h1001_0000);
    chk("t2_c1_memWe", bus2.memWe, 0);
    tick();
    tick();
    chk("t2_c3_dmReady", bus2.dmReady, 1);
    chk("t2_c3_dmRdata", bus2.dmRdata, mem_f(32'h1001_0000));
    chk("t2_c3_ifReady", bus2.ifReady, 0);
    chk("t2_c3_stall", bus2.stall, 1);
    tick();
    chk("t2_c4_memAddr", bus2.memAddr, 32'h0040_0004);
    chk("t2_c4_memEn", bus2.memEn, 1);
    chk("t2_c4_dmReady", bus2.dmReady, 1);
    tick();
    chk("t2_c5_stall", bus2.stall, 1);
    tick();
    chk("t2_c6_ifReady", bus2.ifReady, 1);
    chk("t2_c6_ifRdata", bus2.ifRdata, mem_f(32'h0040_0004));
    chk("t2_c6_dmReady", bus2.dmReady, 1);
    chk("t2_c6_stall", bus2.stall, 0);
    bus2.ifReq = 0; bus2.dmReq = 0;
    tick();
    chk("t2_c7_ifReady", bus2.ifReady, 0);
    chk("t2_c7_dmReady", bus2.dmReady, 0);

    // 3: store followed by fetch
    bus2.dmReq = 1; bus2.dmWrite = 1; bus2.dmAddr = 32'h1001_0008;
    bus2.dmWdata = 32'hDEAD_BEEF;
    bus2.ifReq = 1; bus2.ifAddr = 32'h0040_0008;
    for (int c = 1; c <= 6; c++) begin
      tick();
      chk($sformatf("t3_c%0d_memWe", c), bus2.memWe, (c <= 2));
      chk($sformatf("t3_c%0d_memEn", c), bus2.memEn,
          (c == 1 || c == 2 || c == 4 || c == 5));
      if (c <= 2) chk("t3_memWdata", bus2.memWdata, 32'hDEAD_BEEF);
      if (c == 3) chk("t3_dmReady", bus2.dmReady, 1);
    end
    chk("t3_ifReady", bus2.ifReady, 1);
    chk("t3_stall", bus2.stall, 0);
    bus2.ifReq = 0; bus2.dmReq = 0; bus2.dmWrite = 0;
    tick();

    // 4: fetch flushed mid-access
    bus2.ifReq = 1; bus2.ifAddr = 32'h0040_000C;
    tick();
    bus2.ifReq = 0;
    tick();
    chk("t4_c2_memEn", bus2.memEn, 1);
    tick();
    chk("t4_c3_memEn", bus2.memEn, 0);
    chk("t4_c3_ifReady", bus2.ifReady, 0);
    chk("t4_c3_ifRdata", bus2.ifRdata, mem_f(32'h0040_000C));
    bus2.ifReq = 1; bus2.ifAddr = 32'h0040_0010;
    tick();
    chk("t4_c4_memAddr", bus2.memAddr, 32'h0040_0010);
    chk("t4_c4_memEn", bus2.memEn, 1);
    tick();
    tick();
    chk("t4_c6_ifReady", bus2.ifReady, 1);
    chk("t4_c6_ifRdata", bus2.ifRdata, mem_f(32'h0040_0010));
    bus2.ifReq = 0;
    tick();

    // 5: reset during second BUSY_D cycle
    bus2.dmReq = 1; bus2.dmWrite = 0; bus2.dmAddr = 32'h1001_0010;
    tick();
    tick();
    chk("t5_c2_memEn", bus2.memEn, 1);
    reset = 1; bus2.dmReq = 0;
    tick();
    chk("t5_memEn", bus2.memEn, 0);
    chk("t5_dmReady", bus2.dmReady, 0);
    chk("t5_memAddr", bus2.memAddr, 0);
    chk("t5_memWdata", bus2.memWdata, 0);
    chk("t5_ifRdata", bus2.ifRdata, 0);
    chk("t5_dmRdata", bus2.dmRdata, 0);
    reset = 0;
    tick();
    chk("t5_c4_memEn", bus2.memEn, 0);
    chk("t5_c4_dmReady", bus2.dmReady, 0);

    // 6: LATENCY=1 back-to-back fetches every 3 cycles
    bus1.ifReq = 1; bus1.ifAddr = 32'h0040_0100;
    for (int k = 0; k < 4; k++) begin
      #1 chk("t6_grant_stall", bus1.stall, 1);
      chk("t6_grant_memEn", bus1.memEn, 0);
      tick();
      chk("t6_busy_memEn", bus1.memEn, 1);
      chk("t6_busy_memAddr", bus1.memAddr, 32'h0040_0100 + 4 * k);
      chk("t6_busy_ifReady", bus1.ifReady, 0);
      tick();
      chk("t6_ifReady", bus1.ifReady, 1);
      chk("t6_ifRdata", bus1.ifRdata, mem_f(32'h0040_0100 + 4 * k));
      chk("t6_stall", bus1.stall, 0);
      chk("t6_done_memEn", bus1.memEn, 0);
      bus1.ifAddr = bus1.ifAddr + 4;
      tick();
      chk("t6_clear", bus1.ifReady, 0);
    end
    bus1.ifReq = 0;

    // Randomized traffic on LATENCY=2 against the model
    reset = 1;
    tick();
    reset = 0;
    act = 0; kd = 0; m_we = 0; r_if = 0; r_dm = 0; adv = 1; g = 0;
    m_addr = '0; m_wdata = '0; rd_if = '0; rd_dm = '0;
    for (int c = 0; c < 400; c++) begin
      chk("rnd_memEn", bus2.memEn, act);
      chk("rnd_memWe", bus2.memWe, act && kd && m_we);
      chk("rnd_memAddr", bus2.memAddr, m_addr);
      chk("rnd_memWdata", bus2.memWdata, m_wdata);
      chk("rnd_ifReady", bus2.ifReady, r_if);
      chk("rnd_dmReady", bus2.dmReady, r_dm);
      chk("rnd_ifRdata", bus2.ifRdata, rd_if);
      chk("rnd_dmRdata", bus2.dmRdata, rd_dm);
      if (adv) begin
        bus2.ifReq   = ($urandom_range(0, 3) != 0) && !(act && !kd);
        bus2.ifAddr  = $urandom & 32'hFFFF_FFFC;
        bus2.dmReq   = ($urandom_range(0, 2) == 0) && !(act && kd);
        bus2.dmWrite = 1'($urandom_range(0, 1));
        bus2.dmAddr  = $urandom & 32'hFFFF_FFFC;
        bus2.dmWdata = $urandom;
      end else begin
        if (bus2.ifReq && !r_if && $urandom_range(0, 9) == 0)
          bus2.ifReq = 0;
        if (bus2.dmReq && !r_dm && $urandom_range(0, 9) == 0)
          bus2.dmReq = 0;
      end
      #1;
      p_i = bus2.ifReq && !r_if;
      p_d = bus2.dmReq && !r_dm;
      es  = p_i || p_d;
      chk("rnd_stall", bus2.stall, es);
      done = act && (c == g + L);
      if (done) begin
        if (kd) rd_dm = mem_f(m_addr);
        else    rd_if = mem_f(m_addr);
      end
      if (!es) begin
        r_if = 0;
        r_dm = 0;
      end else begin
        if (done && !kd && bus2.ifReq) r_if = 1;
        if (done && kd && bus2.dmReq)  r_dm = 1;
      end
      if (done) begin
        act = 0;
      end else if (!act && p_d) begin
        act = 1; kd = 1; g = c;
        m_addr = bus2.dmAddr; m_wdata = bus2.dmWdata; m_we = bus2.dmWrite;
      end else if (!act && p_i) begin
        act = 1; kd = 0; g = c;
        m_addr = bus2.ifAddr;
      end
      adv = !es;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
